seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//  Receive-side counterpart of the BCD-to-7-segment decoder. Samples a time-multiplexed,
//  active-low 7-segment bus (segments + one-hot digit select) and re-encodes each digit to BCD.
//  Filters glitches, assembles one multi-digit frame, and hands it out on a valid/ready port.
//  Used for display loop-back checking and for scraping external display drivers.
// PARAMETERS
//  NUM_DIGITS     4   number of multiplexed digits (>=1)
//  STABLE_CYCLES  8   cycles {dig_sel,seg_n} must hold unchanged before a sample is accepted (>=2)
// PORTS
//  clk          in   1             single clock, rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  seg_n        in   7             segments {g,f,e,d,c,b,a}, 0 = lit
//  dig_sel      in   NUM_DIGITS    one-hot active-high digit select, bit i = digit i
//  frame_ready  in   1             consumer accepts frame when high with frame_valid
//  frame_valid  out  1             frame_bcd/frame_err hold a complete frame
//  frame_bcd    out  4*NUM_DIGITS  digit i at [4i+3:4i]
//  frame_err    out  NUM_DIGITS    bit i = digit i held an illegal pattern
//  overrun      out  1             1-cycle pulse: completed frame dropped (output still full)
// BEHAVIOUR
//  Reset (async assert, sync deassert use): frame_valid=0, frame_bcd=0, frame_err=0, overrun=0;
//   stability counter, working digit regs, per-digit "seen" bits all cleared; FSM -> WAIT.
//  Inputs registered once before use (1 sample stage; no synchronizer in this block).
//  FSM: WAIT  - count cycles the registered {dig_sel,seg_n} equals previous cycle; any change
//               reloads count=0. Count reaching STABLE_CYCLES-1 -> ACCEPT.
//       ACCEPT- one cycle: decode and write working slot; -> HOLD.
//       HOLD  - no further accept until {dig_sel,seg_n} changes; on change -> WAIT, count=0.
//  Decode (seg_n hex -> code): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9;
//   7F (blank) -> 4'hA, err=0; any other pattern -> 4'hF, err=1.
//  dig_sel not one-hot (zero or >1 bit) at ACCEPT: sample discarded, no slot written, no err.
//  Slot write: bcd/err of digit i overwritten, seen[i]=1 (re-capture of same digit overwrites).
//  Frame complete: cycle after all seen bits are 1. Then:
//   - output empty, or frame_valid&frame_ready same cycle: load frame_bcd/frame_err, frame_valid=1.
//   - else: overrun=1 for one cycle, frame dropped.
//   Either way seen[] cleared same cycle; working bcd/err retained until overwritten.
//  Handshake: transfer when frame_valid&frame_ready. frame_valid stays high and frame_bcd/err
//   stable until transfer; frame_valid falls cycle after transfer unless new frame loaded.
//  Latency: last digit stable at input -> frame_valid high = 1 (reg) + STABLE_CYCLES + 2 clocks.
//  Counter saturates at STABLE_CYCLES-1; no wrap. Reset mid-frame discards all partial state.
// TESTING
//  1 Drive digits 0..3 = 7,3,0,9 (seg_n 78,30,40,10), 20 cycles each, ready=1 -> one frame,
//    frame_bcd=16'h9037, frame_err=0, frame_valid high exactly one cycle.
//  2 Toggle seg_n every 5 cycles (STABLE_CYCLES=8) on digit 0 -> no slot written, no frame.
//  3 Digit 2 = 7F, digit 1 = 55, others 00 -> frame_bcd=16'h8AF8, frame_err=4'b0010.
//  4 ready=0, send two full frames -> first frame held stable, overrun pulses once on 2nd;
//    raise ready -> first frame transfers, frame_valid drops next cycle.
//  5 dig_sel=4'b0011 stable 20 cycles -> no slot written; dig_sel=0 likewise ignored.
//  6 Assert rst_n=0 after 3 of 4 digits captured -> outputs 0 at once; after release the
//    remaining digit alone produces no frame until all 4 recaptured.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture
//   Samples a time-multiplexed, active-low 7-segment display bus and
//   re-encodes each digit to BCD. A sample is accepted only after
//   {dig_sel,seg_n} has held unchanged long enough to reject glitches.
//   Captured digits are collected into one frame, which is handed out
//   on a valid/ready port.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   seg_n        segments {g,f,e,d,c,b,a}, 0 = lit
//   dig_sel      one-hot active-high digit select, bit i = digit i
//   frame_ready  consumer accepts the frame while frame_valid is high
//   frame_valid  frame_bcd/frame_err hold a complete frame
//   frame_bcd    digit i at [4i+3:4i]; 4'hA = blank, 4'hF = illegal
//   frame_err    bit i set when digit i held an illegal pattern
//   overrun      one-cycle pulse when a completed frame was dropped
module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    overrun
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic [1:0] {WAIT, ACCEPT, HOLD} state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           count, count_next;
    logic [6:0]              seg_r, seg_d;
    logic [NUM_DIGITS-1:0]   sel_r, sel_d;
    logic                    change;
    logic                    accept;
    logic                    slot_write;
    logic [4:0]              dec;
    logic [4*NUM_DIGITS-1:0] work_bcd;
    logic [NUM_DIGITS-1:0]   work_err;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    all_seen;
    logic                    can_load;

    // Returns {err, code}: digits 0-9, blank -> 4'hA, anything else -> 4'hF with err.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h7F:   decode = 5'h0A;
            default: decode = 5'h1F;
        endcase
    endfunction

    // Sample stage plus one delayed copy used for the stability comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= '0;
            sel_r <= '0;
            seg_d <= '0;
            sel_d <= '0;
        end else begin
            seg_r <= seg_n;
            sel_r <= dig_sel;
            seg_d <= seg_r;
            sel_d <= sel_r;
        end
    end

    assign change = (seg_r != seg_d) || (sel_r != sel_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // The jump to ACCEPT happens on the cycle the count reaches its saturation
    // value, so a value stable for STABLE_CYCLES samples is accepted. In ACCEPT
    // the delayed copy still holds the verified value, so it is decoded even if
    // the bus moves that same cycle; the move then re-arms WAIT directly.
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        case (state)
            WAIT: begin
                if (change) begin
                    count_next = '0;
                end else if (count == CW'(STABLE_CYCLES - 2)) begin
                    count_next = CW'(STABLE_CYCLES - 1);
                    state_next = ACCEPT;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            ACCEPT: begin
                accept = 1'b1;
                if (change) begin
                    state_next = WAIT;
                    count_next = '0;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (change) begin
                    state_next = WAIT;
                    count_next = '0;
                end
            end
            default: begin
                state_next = WAIT;
                count_next = '0;
            end
        endcase
    end

    assign dec        = decode(seg_d);
    assign slot_write = accept && $onehot(sel_d);
    assign all_seen   = &seen;
    assign can_load   = !frame_valid || frame_ready;

    // Working digits survive a completed frame; only seen[] is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_bcd <= '0;
            work_err <= '0;
            seen     <= '0;
        end else begin
            if (slot_write) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_d[i]) begin
                        work_bcd[4*i +: 4] <= dec[3:0];
                        work_err[i]        <= dec[4];
                    end
                end
            end
            if (all_seen) begin
                seen <= '0;
            end else if (slot_write) begin
                seen <= seen | sel_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_bcd   <= '0;
            frame_err   <= '0;
            overrun     <= 1'b0;
        end else begin
            overrun <= all_seen && !can_load;
            if (all_seen && can_load) begin
                frame_valid <= 1'b1;
                frame_bcd   <= work_bcd;
                frame_err   <= work_err;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    localparam int N = 4;
    localparam int S = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [6:0]     seg_n;
    logic [N-1:0]   dig_sel;
    logic           frame_ready;
    logic           frame_valid;
    logic [4*N-1:0] frame_bcd;
    logic [N-1:0]   frame_err;
    logic           overrun;

    int compared      = 0;
    int mismatched    = 0;
    int valid_cycles  = 0;
    int overrun_count = 0;
    int transfers     = 0;

    // Scoreboard entries: {err[3:0], bcd[15:0]}
    logic [19:0] exp_q[$];

    seg7_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic show(input int idx, input logic [6:0] seg, input int cyc);
        dig_sel      = '0;
        dig_sel[idx] = 1'b1;
        seg_n        = seg;
        repeat (cyc) tick();
    endtask

    // Output side of the scoreboard: a transfer is seen at the falling edge
    // with the values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) valid_cycles++;
            if (overrun) overrun_count++;
            if (frame_valid && frame_ready) begin
                logic [19:0] e;
                transfers++;
                if (exp_q.size() == 0) begin
                    check("spurious_frame", {12'h0, frame_err, frame_bcd}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bcd", 32'(frame_bcd), 32'(e[15:0]));
                    check("frame_err", 32'(frame_err), 32'(e[19:16]));
                end
            end
        end
    end

    initial begin
        int v0;
        int t0;
        int o0;
        int lat;

        rst_n       = 1'b0;
        seg_n       = 7'h7F;
        dig_sel     = '0;
        frame_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid",   32'(frame_valid), 32'd0);
        check("rst_bcd",     32'(frame_bcd),   32'd0);
        check("rst_err",     32'(frame_err),   32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Test 1: digits 7,3,0,9 -> one frame, plus latency of the last digit.
        v0 = valid_cycles;
        exp_q.push_back({4'b0000, 16'h9037});
        show(0, 7'h78, 20);
        show(1, 7'h30, 20);
        show(2, 7'h40, 20);
        dig_sel = 4'b1000;
        seg_n   = 7'h10;
        lat     = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (frame_valid) begin
                lat = k;
                break;
            end
        end
        check("t1_latency", 32'(lat), 32'(1 + S + 2));
        repeat (10) tick();
        check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("t1_transfers",    32'(transfers),         32'd1);

        // Test 2: digit 0 toggling faster than the filter -> never captured.
        t0 = transfers;
        for (int k = 0; k < 12; k++) begin
            dig_sel = 4'b0001;
            seg_n   = (k % 2 == 0) ? 7'h40 : 7'h79;
            repeat (5) tick();
        end
        show(1, 7'h12, 20);
        show(2, 7'h02, 20);
        show(3, 7'h24, 20);
        check("t2_no_frame",    32'(transfers - t0), 32'd0);
        check("t2_valid_low",   32'(frame_valid),    32'd0);
        exp_q.push_back({4'b0000, 16'h2654});
        show(0, 7'h19, 20);
        check("t2_frame_after", 32'(transfers - t0), 32'd1);

        // Test 3: blank and illegal patterns.
        t0 = transfers;
        exp_q.push_back({4'b0010, 16'h8AF8});
        show(0, 7'h00, 20);
        show(1, 7'h55, 20);
        show(2, 7'h7F, 20);
        show(3, 7'h00, 20);
        check("t3_frames", 32'(transfers - t0), 32'd1);

        // Test 4: consumer stalled, second frame overruns.
        frame_ready = 1'b0;
        t0 = transfers;
        o0 = overrun_count;
        exp_q.push_back({4'b0000, 16'h4321});
        show(0, 7'h79, 20);
        show(1, 7'h24, 20);
        show(2, 7'h30, 20);
        show(3, 7'h19, 20);
        check("t4_valid_held", 32'(frame_valid), 32'd1);
        check("t4_bcd_first",  32'(frame_bcd),   32'h4321);
        show(0, 7'h12, 20);
        show(1, 7'h02, 20);
        show(2, 7'h78, 20);
        show(3, 7'h00, 20);
        check("t4_overrun_once", 32'(overrun_count - o0), 32'd1);
        check("t4_valid_still",  32'(frame_valid),        32'd1);
        check("t4_bcd_stable",   32'(frame_bcd),          32'h4321);
        check("t4_err_stable",   32'(frame_err),          32'd0);
        check("t4_no_transfer",  32'(transfers - t0),     32'd0);
        frame_ready = 1'b1;
        tick();
        check("t4_valid_drop",   32'(frame_valid),        32'd0);
        check("t4_one_transfer", 32'(transfers - t0),     32'd1);

        // Test 5: non-one-hot selects are ignored.
        t0 = transfers;
        dig_sel = 4'b0011;
        seg_n   = 7'h40;
        repeat (20) tick();
        dig_sel = 4'b0000;
        seg_n   = 7'h79;
        repeat (20) tick();
        show(1, 7'h24, 20);
        show(2, 7'h30, 20);
        show(3, 7'h19, 20);
        check("t5_no_frame", 32'(transfers - t0), 32'd0);
        exp_q.push_back({4'b0000, 16'h4327});
        show(0, 7'h78, 20);
        check("t5_frame", 32'(transfers - t0), 32'd1);

        // Test 6: reset mid-frame discards partial digits.
        show(0, 7'h79, 20);
        show(1, 7'h24, 20);
        show(2, 7'h30, 20);
        dig_sel = '0;
        seg_n   = 7'h7F;
        rst_n   = 1'b0;
        #1;
        check("t6_rst_valid",   32'(frame_valid), 32'd0);
        check("t6_rst_bcd",     32'(frame_bcd),   32'd0);
        check("t6_rst_err",     32'(frame_err),   32'd0);
        check("t6_rst_overrun", 32'(overrun),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        t0 = transfers;
        show(3, 7'h19, 20);
        check("t6_no_frame",  32'(transfers - t0), 32'd0);
        check("t6_valid_low", 32'(frame_valid),    32'd0);
        exp_q.push_back({4'b0000, 16'h4956});
        show(0, 7'h02, 20);
        show(1, 7'h12, 20);
        show(2, 7'h10, 20);
        check("t6_frame", 32'(transfers - t0), 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
